// File: rtl/access_pkg.sv
// Shared definitions for the access controller: FSM state encodings and field widths.
// Ports: none (package).
// Imported by access_ctrl and cycle_timer.
package access_pkg;

  // 3-bit state encodings; codes 5..7 are unused and recover to COLLECT.
  typedef logic [2:0] state_t;

  localparam state_t ST_COLLECT = 3'd0;
  localparam state_t ST_CHECK   = 3'd1;
  localparam state_t ST_FAIL    = 3'd2;
  localparam state_t ST_LOCK    = 3'd3;
  localparam state_t ST_GAME    = 3'd4;

  localparam int DIGIT_W = 4;  // width of one password digit
  localparam int IDX_W   = 2;  // digit index 0..3
  localparam int FCNT_W  = 2;  // consecutive failure count 0..3

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with terminal-count flag; shared by the lockout and inactivity timers.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_load/i_load_val preset,
//        i_en count enable, o_tc high while the count is zero.
module cycle_timer #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // Load wins over enable; the count parks at zero instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/access_ctrl.sv
// Four-digit password gate with failure lockout and game-mode inactivity timeout.
// Ports: CLK, RST (async active-low); enter_pulse/logout_pulse/digit_in inputs;
//        game_en, locked, login_fail, timed_out, digit_idx, fail_cnt outputs (all registered/Moore).
module access_ctrl
  import access_pkg::*;
#(
  parameter logic [3:0] PW0            = 4'h1,
  parameter logic [3:0] PW1            = 4'h2,
  parameter logic [3:0] PW2            = 4'h3,
  parameter logic [3:0] PW3            = 4'h4,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCK_CYCLES    = 16,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enter_pulse,
  input  logic               logout_pulse,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic               game_en,
  output logic               locked,
  output logic               login_fail,
  output logic               timed_out,
  output logic [IDX_W-1:0]   digit_idx,
  output logic [FCNT_W-1:0]  fail_cnt
);

  // One timer serves both LOCK and GAME since those states never overlap.
  localparam int TIMER_W = $clog2(max_int(LOCK_CYCLES, TIMEOUT_CYCLES));
  // Loading N-1 and running down to zero gives exactly N cycles in the state.
  localparam logic [TIMER_W-1:0] LOCK_LOAD    = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FCNT_W-1:0]  MAX_FAILS_C  = FCNT_W'(MAX_FAILS);

  state_t              r_state;
  logic [IDX_W-1:0]    r_digit_idx;
  logic [FCNT_W-1:0]   r_fail_cnt;
  logic                r_match;
  logic                r_timed_out;

  state_t              w_state_nxt;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [FCNT_W-1:0]   w_fcnt_nxt;
  logic                w_match_nxt;
  logic                w_timed_out_nxt;
  logic [DIGIT_W-1:0]  w_pw_digit;
  logic [FCNT_W-1:0]   w_fail_inc;
  logic                w_tmr_load;
  logic [TIMER_W-1:0]  w_tmr_val;
  logic                w_tmr_en;
  logic                w_tmr_tc;

  always_comb begin
    w_pw_digit = PW0;
    case (r_digit_idx)
      2'd0:    w_pw_digit = PW0;
      2'd1:    w_pw_digit = PW1;
      2'd2:    w_pw_digit = PW2;
      default: w_pw_digit = PW3;
    endcase
  end

  assign w_fail_inc = (r_fail_cnt == 2'd3) ? 2'd3 : r_fail_cnt + 2'd1;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_digit_idx;
    w_fcnt_nxt      = r_fail_cnt;
    w_match_nxt     = r_match;
    w_timed_out_nxt = 1'b0;
    w_tmr_load      = 1'b0;
    w_tmr_val       = TIMEOUT_LOAD;
    w_tmr_en        = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        if (enter_pulse) begin
          w_match_nxt = r_match & (digit_in == w_pw_digit);
          if (r_digit_idx == 2'd3) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_CHECK;
          end else begin
            w_idx_nxt = r_digit_idx + 2'd1;
          end
        end
      end
      ST_CHECK: begin
        w_match_nxt = 1'b1;
        if (r_match) begin
          w_state_nxt = ST_GAME;
          w_fcnt_nxt  = '0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TIMEOUT_LOAD;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_FAIL: begin
        w_fcnt_nxt = w_fail_inc;
        if (w_fail_inc == MAX_FAILS_C) begin
          w_state_nxt = ST_LOCK;
          w_tmr_load  = 1'b1;
          w_tmr_val   = LOCK_LOAD;
        end else begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_LOCK: begin
        if (w_tmr_tc) begin
          w_state_nxt = ST_COLLECT;
          w_fcnt_nxt  = '0;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      ST_GAME: begin
        // Logout has priority over both activity and timeout.
        if (logout_pulse) begin
          w_state_nxt = ST_COLLECT;
          w_idx_nxt   = '0;
        end else if (enter_pulse) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = TIMEOUT_LOAD;
        end else if (w_tmr_tc) begin
          w_state_nxt     = ST_COLLECT;
          w_idx_nxt       = '0;
          w_timed_out_nxt = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_COLLECT;
        w_idx_nxt   = '0;
        w_match_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_COLLECT;
      r_digit_idx <= '0;
      r_fail_cnt  <= '0;
      r_match     <= 1'b1;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_digit_idx <= w_idx_nxt;
      r_fail_cnt  <= w_fcnt_nxt;
      r_match     <= w_match_nxt;
      r_timed_out <= w_timed_out_nxt;
    end
  end

  cycle_timer #(
    .W (TIMER_W)
  ) u_timer (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_tc       (w_tmr_tc)
  );

  assign game_en    = (r_state == ST_GAME);
  assign locked     = (r_state == ST_LOCK);
  assign login_fail = (r_state == ST_FAIL);
  assign timed_out  = r_timed_out;
  assign digit_idx  = r_digit_idx;
  assign fail_cnt   = r_fail_cnt;

endmodule

// File: doc/access_ctrl.md
ACCESS_CTRL -- requirements
Module: access_ctrl

Interface
REQ-001 Parameter PW0  default 4'h1  first password digit.
REQ-002 Parameter PW1  default 4'h2  second password digit.
REQ-003 Parameter PW2  default 4'h3  third password digit.
REQ-004 Parameter PW3  default 4'h4  fourth password digit.
REQ-005 Parameter MAX_FAILS  default 3  consecutive failed logins before lockout; legal range 1..3.
REQ-006 Parameter LOCK_CYCLES  default 16  lockout duration in clocks; minimum 2.
REQ-007 Parameter TIMEOUT_CYCLES  default 64  game-mode inactivity limit in clocks; minimum 2.
REQ-008 CLK  in  1  single clock; all state updates on the rising edge.
REQ-009 RST  in  1  reset; asynchronous, active-low.
REQ-010 enter_pulse  in  1  one-cycle pulse from a button one-shot; submits a digit or marks activity.
REQ-011 logout_pulse  in  1  one-cycle pulse; leaves game mode.
REQ-012 digit_in  in  4  switch value sampled on enter_pulse.
REQ-013 game_en  out  1  high while in GAME state.
REQ-014 locked  out  1  high while in LOCK state.
REQ-015 login_fail  out  1  one-cycle pulse per failed login.
REQ-016 timed_out  out  1  one-cycle pulse when game mode ends by inactivity.
REQ-017 digit_idx  out  2  index of next digit expected (0..3).
REQ-018 fail_cnt  out  2  current consecutive failure count.

Function
REQ-019 The FSM SHALL have states COLLECT, CHECK, FAIL, LOCK, GAME; all outputs Moore-decoded from state and registers.
REQ-020 In COLLECT, each enter_pulse SHALL update match <= match AND (digit_in == PWn[digit_idx]) and increment digit_idx.
REQ-021 The enter_pulse at digit_idx==3 SHALL move to CHECK and wrap digit_idx to 0.
REQ-022 CHECK SHALL last exactly one cycle, then go to GAME if match==1, else FAIL; match SHALL reset to 1 on leaving CHECK.
REQ-023 game_en SHALL assert on the second rising edge after the edge sampling the fourth enter_pulse.
REQ-024 Entering GAME SHALL clear fail_cnt to 0.
REQ-025 FAIL SHALL last one cycle with login_fail=1, increment fail_cnt (saturating at 3), then go to LOCK if incremented fail_cnt == MAX_FAILS, else COLLECT.
REQ-026 LOCK SHALL hold locked=1 for exactly LOCK_CYCLES clocks, then go to COLLECT with fail_cnt=0.
REQ-027 enter_pulse and logout_pulse SHALL be ignored in CHECK, FAIL and LOCK; logout_pulse SHALL be ignored in COLLECT.
REQ-028 In GAME, logout_pulse SHALL go to COLLECT next cycle with digit_idx=0.
REQ-029 In GAME, an inactivity counter SHALL clear on every enter_pulse and on GAME entry, and increment otherwise.
REQ-030 When the inactivity counter reaches TIMEOUT_CYCLES-1 with no enter_pulse, the FSM SHALL go to COLLECT and pulse timed_out for one cycle.
REQ-031 Simultaneous logout_pulse and timeout in GAME SHALL be treated as logout (no timed_out pulse).
REQ-032 Simultaneous logout_pulse and enter_pulse in GAME SHALL be treated as logout.
REQ-033 Undefined state encodings SHALL return to COLLECT.

Reset
REQ-034 RST low SHALL immediately force state COLLECT, digit_idx=0, fail_cnt=0, match=1, timers=0, and all outputs 0, independent of CLK.
REQ-035 Reset asserted mid-entry, mid-lock or mid-game SHALL discard all progress; the first enter_pulse after release is digit 0.

Structure
REQ-036 Package access_pkg SHALL hold the state typedef/encodings (3-bit) and the digit and fail-count widths.
REQ-037 One sub-module cycle_timer (load, enable, terminal-count flag, parameterised width) SHALL implement both the lock and inactivity timers.

Verification
REQ-038 Digits 1,2,3,4 on four pulses -> CHECK, then game_en=1 two edges after the fourth pulse; fail_cnt=0.
REQ-039 Digits 1,2,9,4 -> exactly one login_fail pulse, fail_cnt=1, state COLLECT, digit_idx=0.
REQ-040 Three wrong sequences -> locked=1 for exactly 16 clocks; pulses during lock ignored; then fail_cnt=0, locked=0.
REQ-041 In GAME with no pulses for 64 clocks -> timed_out one-cycle pulse, game_en=0; an enter_pulse every 60 clocks keeps game_en=1.
REQ-042 logout_pulse coincident with timeout cycle -> game_en=0, timed_out stays 0.
REQ-043 RST low after two correct digits -> outputs 0 immediately; next sequence 1,2,3,4 grants GAME.
